// File: rtl/sh_prio_intc_pkg.sv
// Shared types and constants for the SH priority interrupt controller.
// The config register layout is fixed at 16 bits; narrower PRIO/VEC fields are zero-extended.
package sh_prio_intc_pkg;

   typedef struct packed {
      logic       mode;
      logic       pend;
      logic [1:0] rsvd;
      logic [3:0] prio;
      logic [7:0] vec;
   } cfg_reg_t;

   localparam logic [15:0] CFG_WMASK = 16'hCFFF;
   localparam logic [15:0] CFG_RMASK = 16'hCFFF;
   localparam int          NMI_VEC   = 11;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_ACCEPTED = 1'b1
   } state_t;

   function automatic logic [15:0] cfg_pack(
      input logic       mode,
      input logic       pend,
      input logic [3:0] prio,
      input logic [7:0] vec
   );
      cfg_reg_t c;
      c.mode = mode;
      c.pend = pend;
      c.rsvd = 2'b00;
      c.prio = prio;
      c.vec  = vec;
      return c;
   endfunction

endpackage

// File: rtl/sh_prio_arb.sv
// Combinational NSRC-way max-priority select returning valid, level and index.
// Strictly-greater comparison while scanning upward keeps the lowest index on ties.
module sh_prio_arb #(
   parameter int NSRC  = 16,
   parameter int LVL_W = 4,
   parameter int IW    = $clog2(NSRC)
) (
   input  logic [NSRC-1:0]       i_cand,
   input  logic [NSRC*LVL_W-1:0] i_prio,
   output logic                  o_valid,
   output logic [LVL_W-1:0]      o_lvl,
   output logic [IW-1:0]         o_idx
);

   logic             w_valid;
   logic [LVL_W-1:0] w_lvl;
   logic [IW-1:0]    w_idx;

   always_comb begin
      w_valid = 1'b0;
      w_lvl   = '0;
      w_idx   = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (i_cand[i] && (!w_valid || (i_prio[i*LVL_W +: LVL_W] > w_lvl))) begin
            w_valid = 1'b1;
            w_lvl   = i_prio[i*LVL_W +: LVL_W];
            w_idx   = IW'(i);
         end
      end
   end

   assign o_valid = w_valid;
   assign o_lvl   = w_lvl;
   assign o_idx   = w_idx;

endmodule

// File: rtl/sh_prio_intc.sv
// SH priority interrupt controller: N configurable sources plus NMI, arbitrated against the
// CPU mask, with the accepted vector held until the CPU acknowledges.
module sh_prio_intc
   import sh_prio_intc_pkg::*;
#(
   parameter int  NSRC  = 16,
   parameter int  LVL_W = 4,
   parameter int  VEC_W = 8,
   localparam int IW    = $clog2(NSRC)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ce,
   input  logic              i_nmi_n,
   input  logic              i_nmi_edge,
   input  logic [NSRC-1:0]   i_src_irq,
   input  logic [LVL_W-1:0]  i_int_mask,
   output logic              o_int_req,
   output logic [LVL_W-1:0]  o_int_lvl,
   output logic [VEC_W-1:0]  o_int_vec,
   input  logic              i_int_acp,
   input  logic              i_int_ack,
   input  logic [IW-1:0]     i_reg_a,
   input  logic [15:0]       i_reg_di,
   input  logic              i_reg_we,
   input  logic              i_reg_req,
   output logic [15:0]       o_reg_do
);

   state_t               r_state;
   logic                 r_int_req;
   logic [LVL_W-1:0]     r_int_lvl;
   logic [VEC_W-1:0]     r_int_vec;
   logic [IW-1:0]        r_win_idx;
   logic                 r_win_nmi;
   logic                 r_nmi_q;
   logic                 r_nmi_pend;
   logic [15:0]          r_reg_do;

   cfg_reg_t             w_wr;
   logic [15:0]          w_rd;
   logic                 w_accept;
   logic                 w_nmi_trig;
   logic [NSRC-1:0]      w_pend;
   logic [NSRC-1:0]      w_mode;
   logic [NSRC-1:0]      w_cand;
   logic [NSRC*LVL_W-1:0] w_prio_flat;
   logic [NSRC*VEC_W-1:0] w_vec_flat;
   logic [VEC_W-1:0]     w_win_vec;
   logic                 w_arb_valid;
   logic [LVL_W-1:0]     w_arb_lvl;
   logic [IW-1:0]        w_arb_idx;
   logic                 w_unused;

   assign w_wr       = cfg_reg_t'(i_reg_di & CFG_WMASK);
   assign w_unused   = ^w_wr.rsvd;
   assign w_accept   = i_ce && (r_state == ST_IDLE) && i_int_acp && r_int_req;
   assign w_nmi_trig = i_nmi_edge ? (i_nmi_n && !r_nmi_q) : (!i_nmi_n && r_nmi_q);
   assign w_win_vec  = w_vec_flat[r_win_idx*VEC_W +: VEC_W];

   genvar gi;
   generate
      for (gi = 0; gi < NSRC; gi++) begin : g_src
         logic             r_src_q;
         logic             r_pend_e;
         logic             r_mode;
         logic [LVL_W-1:0] r_prio;
         logic [VEC_W-1:0] r_vec;
         logic             w_wsel;
         logic             w_rise;
         logic             w_clr;

         assign w_wsel = i_reg_req && i_reg_we && (i_reg_a == IW'(gi));
         assign w_rise = i_src_irq[gi] && !r_src_q;
         assign w_clr  = (w_accept && !r_win_nmi && (r_win_idx == IW'(gi))) ||
                         (w_wsel && w_wr.pend);

         // A new edge outranks any clear arriving in the same cycle.
         always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
               r_src_q  <= 1'b0;
               r_pend_e <= 1'b0;
               r_mode   <= 1'b0;
               r_prio   <= '0;
               r_vec    <= '0;
            end else if (i_ce) begin
               r_src_q  <= i_src_irq[gi];
               r_pend_e <= (r_mode && w_rise) || (r_pend_e && !w_clr);
               if (w_wsel) begin
                  r_mode <= w_wr.mode;
                  r_prio <= w_wr.prio[LVL_W-1:0];
                  r_vec  <= w_wr.vec[VEC_W-1:0];
               end
            end
         end

         assign w_pend[gi] = r_mode ? r_pend_e : r_src_q;
         assign w_mode[gi] = r_mode;
         assign w_cand[gi] = w_pend[gi] && (r_prio > i_int_mask);
         assign w_prio_flat[gi*LVL_W +: LVL_W] = r_prio;
         assign w_vec_flat[gi*VEC_W +: VEC_W]  = r_vec;
      end
   endgenerate

   always_comb begin
      w_rd = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (i_reg_a == IW'(i)) begin
            w_rd = cfg_pack(w_mode[i], w_pend[i],
                            4'(w_prio_flat[i*LVL_W +: LVL_W]),
                            8'(w_vec_flat[i*VEC_W +: VEC_W])) & CFG_RMASK;
         end
      end
   end

   sh_prio_arb #(
      .NSRC  (NSRC),
      .LVL_W (LVL_W),
      .IW    (IW)
   ) u_arb (
      .i_cand  (w_cand),
      .i_prio  (w_prio_flat),
      .o_valid (w_arb_valid),
      .o_lvl   (w_arb_lvl),
      .o_idx   (w_arb_idx)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_IDLE;
         r_int_req  <= 1'b0;
         r_int_lvl  <= '0;
         r_int_vec  <= '0;
         r_win_idx  <= '0;
         r_win_nmi  <= 1'b0;
         r_nmi_q    <= !i_nmi_edge;
         r_nmi_pend <= 1'b0;
         r_reg_do   <= '0;
      end else if (i_ce) begin
         r_nmi_q    <= i_nmi_n;
         r_nmi_pend <= w_nmi_trig || (r_nmi_pend && !(w_accept && r_win_nmi));
         // NMI bypasses the mask and always sits at the top level.
         r_int_req  <= r_nmi_pend || w_arb_valid;
         r_int_lvl  <= r_nmi_pend ? '1 : w_arb_lvl;
         r_win_nmi  <= r_nmi_pend;
         r_win_idx  <= w_arb_idx;
         if (i_reg_req) begin
            r_reg_do <= w_rd;
         end
         case (r_state)
            ST_IDLE: begin
               if (i_int_acp && r_int_req) begin
                  r_int_vec <= r_win_nmi ? VEC_W'(NMI_VEC) : w_win_vec;
                  r_state   <= ST_ACCEPTED;
               end
            end
            ST_ACCEPTED: begin
               if (i_int_ack) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_int_req = r_int_req;
   assign o_int_lvl = r_int_lvl;
   assign o_int_vec = r_int_vec;
   assign o_reg_do  = r_reg_do;

endmodule

// File: tb/tb_sh_prio_intc.sv
// Directed bench for sh_prio_intc: per-feature tasks with hand-computed expectations.
module tb_sh_prio_intc;

   logic        clk;
   logic        rst_n;
   logic        ce;
   logic        nmi_n;
   logic        nmi_edge;
   logic [15:0] src_irq;
   logic [3:0]  int_mask;
   logic        int_req;
   logic [3:0]  int_lvl;
   logic [7:0]  int_vec;
   logic        int_acp;
   logic        int_ack;
   logic [3:0]  reg_a;
   logic [15:0] reg_di;
   logic        reg_we;
   logic        reg_req;
   logic [15:0] reg_do;

   int total = 0;
   int bad   = 0;

   sh_prio_intc #(
      .NSRC  (16),
      .LVL_W (4),
      .VEC_W (8)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_ce       (ce),
      .i_nmi_n    (nmi_n),
      .i_nmi_edge (nmi_edge),
      .i_src_irq  (src_irq),
      .i_int_mask (int_mask),
      .o_int_req  (int_req),
      .o_int_lvl  (int_lvl),
      .o_int_vec  (int_vec),
      .i_int_acp  (int_acp),
      .i_int_ack  (int_ack),
      .i_reg_a    (reg_a),
      .i_reg_di   (reg_di),
      .i_reg_we   (reg_we),
      .i_reg_req  (reg_req),
      .o_reg_do   (reg_do)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
      reg_a = a; reg_di = d; reg_we = 1'b1; reg_req = 1'b1;
      tick();
      reg_we = 1'b0; reg_req = 1'b0;
   endtask

   task automatic reg_rd(input logic [3:0] a);
      reg_a = a; reg_we = 1'b0; reg_req = 1'b1;
      tick();
      reg_req = 1'b0;
   endtask

   task automatic accept();
      int_acp = 1'b1;
      tick();
      int_acp = 1'b0;
   endtask

   task automatic acknowledge();
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; ce = 1'b1; nmi_n = 1'b1; nmi_edge = 1'b0; src_irq = '0;
      int_mask = 4'd0; int_acp = 1'b0; int_ack = 1'b0;
      reg_a = '0; reg_di = '0; reg_we = 1'b0; reg_req = 1'b0;
      tick(); tick(); tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", int_req); end
      total++; if (int_lvl !== 4'd0) begin bad++; $display("FAIL reset_lvl got=%h want=0", int_lvl); end
      total++; if (int_vec !== 8'd0) begin bad++; $display("FAIL reset_vec got=%h want=00", int_vec); end
      total++; if (reg_do !== 16'd0) begin bad++; $display("FAIL reset_regdo got=%h want=0000", reg_do); end
      rst_n = 1'b1;
      tick();
      reg_rd(4'd0);
      total++; if (reg_do !== 16'h0000) begin bad++; $display("FAIL reset_cfg0 got=%h want=0000", reg_do); end
      $display("test_reset done");
   endtask

   task automatic test_edge_basic();
      int_mask = 4'd4;
      reg_wr(4'd3, 16'h8540);
      reg_rd(4'd3);
      total++; if (reg_do !== 16'h8540) begin bad++; $display("FAIL edge_cfg got=%h want=8540", reg_do); end
      src_irq[3] = 1'b1;
      tick();
      src_irq[3] = 1'b0;
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL edge_req_early got=%b want=0", int_req); end
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL edge_req got=%b want=1", int_req); end
      total++; if (int_lvl !== 4'd5) begin bad++; $display("FAIL edge_lvl got=%h want=5", int_lvl); end
      reg_rd(4'd3);
      total++; if (reg_do !== 16'hC540) begin bad++; $display("FAIL edge_pend_rd got=%h want=c540", reg_do); end
      accept();
      total++; if (int_vec !== 8'h40) begin bad++; $display("FAIL edge_vec got=%h want=40", int_vec); end
      reg_rd(4'd3);
      total++; if (reg_do !== 16'h8540) begin bad++; $display("FAIL edge_pend_clr got=%h want=8540", reg_do); end
      acknowledge();
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL edge_req_after got=%b want=0", int_req); end
      $display("test_edge_basic done");
   endtask

   task automatic test_tie();
      int_mask = 4'd4;
      reg_wr(4'd2, 16'h8922);
      reg_wr(4'd7, 16'h8977);
      src_irq[2] = 1'b1; src_irq[7] = 1'b1;
      tick();
      src_irq[2] = 1'b0; src_irq[7] = 1'b0;
      tick();
      total++; if (int_lvl !== 4'd9) begin bad++; $display("FAIL tie_lvl got=%h want=9", int_lvl); end
      accept();
      total++; if (int_vec !== 8'h22) begin bad++; $display("FAIL tie_vec got=%h want=22", int_vec); end
      acknowledge();
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL tie_req7 got=%b want=1", int_req); end
      reg_wr(4'd7, 16'h8A77);
      tick();
      total++; if (int_lvl !== 4'd10) begin bad++; $display("FAIL tie_lvl10 got=%h want=a", int_lvl); end
      accept();
      total++; if (int_vec !== 8'h77) begin bad++; $display("FAIL tie_vec7 got=%h want=77", int_vec); end
      acknowledge();
      tick(); tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL tie_req_after got=%b want=0", int_req); end
      $display("test_tie done");
   endtask

   task automatic test_mask();
      reg_wr(4'd5, 16'h8955);
      int_mask = 4'd9;
      src_irq[5] = 1'b1;
      tick();
      src_irq[5] = 1'b0;
      tick(); tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask9_req got=%b want=0", int_req); end
      int_mask = 4'd8;
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL mask8_req got=%b want=1", int_req); end
      total++; if (int_lvl !== 4'd9) begin bad++; $display("FAIL mask8_lvl got=%h want=9", int_lvl); end
      reg_wr(4'd5, 16'hC955);
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL swclr_req got=%b want=0", int_req); end
      reg_rd(4'd5);
      total++; if (reg_do !== 16'h8955) begin bad++; $display("FAIL swclr_rd got=%h want=8955", reg_do); end
      $display("test_mask done");
   endtask

   task automatic test_nmi();
      int_mask = 4'd15;
      nmi_n = 1'b0;
      tick();
      nmi_n = 1'b1;
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL nmi_req got=%b want=1", int_req); end
      total++; if (int_lvl !== 4'd15) begin bad++; $display("FAIL nmi_lvl got=%h want=f", int_lvl); end
      accept();
      total++; if (int_vec !== 8'h0B) begin bad++; $display("FAIL nmi_vec got=%h want=0b", int_vec); end
      acknowledge();
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL nmi_req_after got=%b want=0", int_req); end
      accept();
      total++; if (int_vec !== 8'h0B) begin bad++; $display("FAIL acp_noreq_vec got=%h want=0b", int_vec); end
      $display("test_nmi done");
   endtask

   task automatic test_level();
      int_mask = 4'd4;
      reg_wr(4'd6, 16'h0766);
      src_irq[6] = 1'b1;
      tick(); tick();
      total++; if (int_lvl !== 4'd7) begin bad++; $display("FAIL lvl_lvl got=%h want=7", int_lvl); end
      accept();
      total++; if (int_vec !== 8'h66) begin bad++; $display("FAIL lvl_vec got=%h want=66", int_vec); end
      acknowledge();
      tick();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL lvl_reassert got=%b want=1", int_req); end
      reg_rd(4'd6);
      total++; if (reg_do !== 16'h4766) begin bad++; $display("FAIL lvl_rd got=%h want=4766", reg_do); end
      src_irq[6] = 1'b0;
      tick(); tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lvl_drop got=%b want=0", int_req); end
      $display("test_level done");
   endtask

   task automatic test_ce();
      ce = 1'b0;
      src_irq[3] = 1'b1;
      tick();
      src_irq[3] = 1'b0;
      tick();
      ce = 1'b1;
      tick(); tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL ce_req got=%b want=0", int_req); end
      reg_rd(4'd3);
      total++; if (reg_do !== 16'h8540) begin bad++; $display("FAIL ce_rd got=%h want=8540", reg_do); end
      $display("test_ce done");
   endtask

   task automatic test_collisions();
      int_mask = 4'd4;
      reg_wr(4'd9, 16'h8599);
      src_irq[9] = 1'b1;
      reg_wr(4'd9, 16'hC599);
      src_irq[9] = 1'b0;
      reg_rd(4'd9);
      total++; if (reg_do !== 16'hC599) begin bad++; $display("FAIL swhw_rd got=%h want=c599", reg_do); end
      reg_wr(4'd4, 16'h8644);
      src_irq[4] = 1'b1;
      tick();
      src_irq[4] = 1'b0;
      tick();
      total++; if (int_lvl !== 4'd6) begin bad++; $display("FAIL coll_lvl got=%h want=6", int_lvl); end
      src_irq[4] = 1'b1;
      accept();
      src_irq[4] = 1'b0;
      total++; if (int_vec !== 8'h44) begin bad++; $display("FAIL coll_vec got=%h want=44", int_vec); end
      reg_rd(4'd4);
      total++; if (reg_do !== 16'hC644) begin bad++; $display("FAIL coll_rd got=%h want=c644", reg_do); end
      rst_n = 1'b0;
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rstacc_req got=%b want=0", int_req); end
      total++; if (int_lvl !== 4'd0) begin bad++; $display("FAIL rstacc_lvl got=%h want=0", int_lvl); end
      total++; if (int_vec !== 8'd0) begin bad++; $display("FAIL rstacc_vec got=%h want=00", int_vec); end
      total++; if (reg_do !== 16'd0) begin bad++; $display("FAIL rstacc_regdo got=%h want=0000", reg_do); end
      rst_n = 1'b1;
      reg_rd(4'd4);
      total++; if (reg_do !== 16'h0000) begin bad++; $display("FAIL rstacc_cfg got=%h want=0000", reg_do); end
      tick();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rstacc_req_after got=%b want=0", int_req); end
      $display("test_collisions done");
   endtask

   initial begin
      test_reset();
      test_edge_basic();
      test_tie();
      test_mask();
      test_nmi();
      test_level();
      test_ce();
      test_collisions();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
